// File: rtl/rtc_seg_scan.sv
// rtc_seg_scan: time-multiplexed 7-segment driver for the stopwatch/RTC display.
// Scans one digit per REFRESH_DIV-clock slot onto a shared cathode bus. Each slot
// starts with one all-dark gap cycle. The input word is snapshotted once per frame,
// so the display changes only at frame boundaries. The driver also provides
// leading-zero blanking, per-digit decimal points and optional hex glyphs.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_rst_n     synchronous reset, active low
//   i_count     4*N_DIGITS BCD/hex word, digit k = i_count[4k+3:4k], digit 0 rightmost
//   i_dp_mask   1 = light the decimal point of digit k
//   i_blank_lz  1 = blank leading zeros (sampled live)
//   i_en        0 = all digits dark; scanning and snapshots continue
//   o_seg       {dp,g,f,e,d,c,b,a}, active low
//   o_an        digit anodes, active low, at most one low
//   o_frame     1-cycle pulse when a new snapshot is taken
module rtc_seg_scan #(
  parameter int unsigned N_DIGITS    = 8,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          HEX_EN      = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [4*N_DIGITS-1:0] i_count,
  input  logic [N_DIGITS-1:0]   i_dp_mask,
  input  logic                  i_blank_lz,
  input  logic                  i_en,
  output logic [7:0]            o_seg,
  output logic [N_DIGITS-1:0]   o_an,
  output logic                  o_frame
);

  localparam int unsigned IdxW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned PrescW = $clog2(REFRESH_DIV);
  localparam logic [IdxW-1:0]   LastIdx  = IdxW'(N_DIGITS - 1);
  localparam logic [PrescW-1:0] PrescMax = PrescW'(REFRESH_DIV - 1);

  logic [PrescW-1:0]     presc_q, presc_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [4*N_DIGITS-1:0] shadow_count_q, shadow_count_d;
  logic [N_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [7:0]            seg_q, seg_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic                  frame_q, frame_d;
  logic                  drive_q, drive_d;
  logic                  en_prev_q, en_prev_d;

  logic                  tick;
  logic [3:0]            nibble;
  logic [N_DIGITS-1:0]   upper_zero;
  logic                  zero_acc;
  logic                  blank;
  logic [7:0]            lit_seg;
  logic [N_DIGITS-1:0]   lit_an;

  function automatic logic [7:0] glyph(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'h0:    g = 8'hC0;
      4'h1:    g = 8'hF9;
      4'h2:    g = 8'hA4;
      4'h3:    g = 8'hB0;
      4'h4:    g = 8'h99;
      4'h5:    g = 8'h92;
      4'h6:    g = 8'h82;
      4'h7:    g = 8'hF8;
      4'h8:    g = 8'h80;
      4'h9:    g = 8'h90;
      4'hA:    g = HEX_EN ? 8'h88 : 8'hBF;
      4'hB:    g = HEX_EN ? 8'h83 : 8'hBF;
      4'hC:    g = HEX_EN ? 8'hC6 : 8'hBF;
      4'hD:    g = HEX_EN ? 8'hA1 : 8'hBF;
      4'hE:    g = HEX_EN ? 8'h86 : 8'hBF;
      default: g = HEX_EN ? 8'h8E : 8'hBF;
    endcase
    return g;
  endfunction

  // Glyph for the currently selected shadow digit.
  always_comb begin
    tick   = (presc_q == PrescMax);
    nibble = shadow_count_q[{idx_q, 2'b00} +: 4];

    // upper_zero[k]: shadow nibbles k..N_DIGITS-1 are all zero.
    zero_acc   = 1'b1;
    upper_zero = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      zero_acc      = zero_acc & (shadow_count_q[4*k +: 4] == 4'h0);
      upper_zero[k] = zero_acc;
    end

    blank   = i_blank_lz && (idx_q != '0) && upper_zero[idx_q] && !shadow_dp_q[idx_q];
    lit_seg = glyph(nibble);
    lit_seg[7] = ~shadow_dp_q[idx_q];
    lit_an  = ~(N_DIGITS'(1) << idx_q);
  end

  always_comb begin
    presc_d        = tick ? '0 : presc_q + 1'b1;
    idx_d          = idx_q;
    shadow_count_d = shadow_count_q;
    shadow_dp_d    = shadow_dp_q;
    seg_d          = seg_q;
    an_d           = an_q;
    frame_d        = 1'b0;
    drive_d        = 1'b0;
    en_prev_d      = i_en;

    if (tick) begin
      // Gap cycle: everything dark while the anode switches.
      idx_d   = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
      seg_d   = 8'hFF;
      an_d    = '1;
      drive_d = 1'b1;
      if (idx_q == LastIdx) begin
        shadow_count_d = i_count;
        shadow_dp_d    = i_dp_mask;
        frame_d        = 1'b1;
      end
    end else if (!i_en) begin
      seg_d = 8'hFF;
      an_d  = '1;
    end else if (drive_q || !en_prev_q) begin
      // Drive cycle after a gap, or re-enable mid-slot.
      if (blank) begin
        seg_d = 8'hFF;
        an_d  = '1;
      end else begin
        seg_d = lit_seg;
        an_d  = lit_an;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      presc_q        <= '0;
      idx_q          <= LastIdx;
      shadow_count_q <= '0;
      shadow_dp_q    <= '0;
      seg_q          <= 8'hFF;
      an_q           <= '1;
      frame_q        <= 1'b0;
      drive_q        <= 1'b0;
      // Treated as already enabled so nothing lights before the first snapshot.
      en_prev_q      <= 1'b1;
    end else begin
      presc_q        <= presc_d;
      idx_q          <= idx_d;
      shadow_count_q <= shadow_count_d;
      shadow_dp_q    <= shadow_dp_d;
      seg_q          <= seg_d;
      an_q           <= an_d;
      frame_q        <= frame_d;
      drive_q        <= drive_d;
      en_prev_q      <= en_prev_d;
    end
  end

  assign o_seg   = seg_q;
  assign o_an    = an_q;
  assign o_frame = frame_q;

endmodule

// File: tb/tb_rtc_seg_scan.sv
// Testbench for rtc_seg_scan with N_DIGITS=4, REFRESH_DIV=4. Two instances share the
// stimulus: one with HEX_EN=0 and one with HEX_EN=1.
module tb_rtc_seg_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] count;
  logic [3:0]  dp_mask;
  logic        blank_lz;
  logic        en;
  logic [7:0]  seg, seg_h;
  logic [3:0]  an, an_h;
  logic        frame, frame_h;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rtc_seg_scan #(.N_DIGITS(4), .REFRESH_DIV(4), .HEX_EN(1'b0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_count(count), .i_dp_mask(dp_mask),
    .i_blank_lz(blank_lz), .i_en(en), .o_seg(seg), .o_an(an), .o_frame(frame)
  );

  rtc_seg_scan #(.N_DIGITS(4), .REFRESH_DIV(4), .HEX_EN(1'b1)) dut_hex (
    .i_clk(clk), .i_rst_n(rst_n), .i_count(count), .i_dp_mask(dp_mask),
    .i_blank_lz(blank_lz), .i_en(en), .o_seg(seg_h), .o_an(an_h), .o_frame(frame_h)
  );

  typedef struct {
    logic [15:0] cnt;
    logic [3:0]  dp;
    logic        blz;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [7:0]  seg_hex;
    logic        frame;
  } vec_t;

  vec_t vec[20];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Slot from just after a drive edge: two hold edges, tick (gap), drive.
  task automatic run_slot(input string name, input logic [3:0] exp_an,
                          input logic [7:0] exp_seg, input logic [7:0] exp_seg_hex,
                          input logic exp_frame);
    step();
    step();
    step();
    chk({name, " gap an"}, {4'h0, an}, 8'h0F);
    chk({name, " gap seg"}, seg, 8'hFF);
    chk({name, " gap frame"}, {7'h0, frame}, {7'h0, exp_frame});
    step();
    chk({name, " an"}, {4'h0, an}, {4'h0, exp_an});
    chk({name, " seg"}, seg, exp_seg);
    chk({name, " hex seg"}, seg_h, exp_seg_hex);
    chk({name, " hex an"}, {4'h0, an_h}, {4'h0, exp_an});
    chk({name, " frame low"}, {7'h0, frame}, 8'h00);
  endtask

  // From reset held low: release, three dark edges, snapshot tick, digit 0 lit.
  task automatic startup(input string name);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk({name, " pre-tick an"}, {4'h0, an}, 8'h0F);
      chk({name, " pre-tick frame"}, {7'h0, frame}, 8'h00);
    end
    step();
    chk({name, " first frame"}, {7'h0, frame}, 8'h01);
    chk({name, " first gap an"}, {4'h0, an}, 8'h0F);
    step();
    chk({name, " digit0 an"}, {4'h0, an}, 8'h0E);
    chk({name, " digit0 seg"}, seg, 8'h99);
  endtask

  initial begin
    vec[0]  = '{16'h1234, 4'b0000, 1'b0, 4'b1101, 8'hB0, 8'hB0, 1'b0};
    vec[1]  = '{16'h1234, 4'b0000, 1'b0, 4'b1011, 8'hA4, 8'hA4, 1'b0};
    vec[2]  = '{16'h1234, 4'b0000, 1'b0, 4'b0111, 8'hF9, 8'hF9, 1'b0};
    vec[3]  = '{16'h1234, 4'b0000, 1'b0, 4'b1110, 8'h99, 8'h99, 1'b1};
    vec[4]  = '{16'h1234, 4'b0000, 1'b0, 4'b1101, 8'hB0, 8'hB0, 1'b0};
    vec[5]  = '{16'h5678, 4'b0000, 1'b0, 4'b1011, 8'hA4, 8'hA4, 1'b0};
    vec[6]  = '{16'h5678, 4'b0000, 1'b0, 4'b0111, 8'hF9, 8'hF9, 1'b0};
    vec[7]  = '{16'h5678, 4'b0000, 1'b0, 4'b1110, 8'h80, 8'h80, 1'b1};
    vec[8]  = '{16'h5678, 4'b0000, 1'b0, 4'b1101, 8'hF8, 8'hF8, 1'b0};
    vec[9]  = '{16'h5678, 4'b0000, 1'b0, 4'b1011, 8'h82, 8'h82, 1'b0};
    vec[10] = '{16'h5678, 4'b0000, 1'b0, 4'b0111, 8'h92, 8'h92, 1'b0};
    vec[11] = '{16'h0070, 4'b0100, 1'b1, 4'b1110, 8'hC0, 8'hC0, 1'b1};
    vec[12] = '{16'h0070, 4'b0100, 1'b1, 4'b1101, 8'hF8, 8'hF8, 1'b0};
    vec[13] = '{16'h0070, 4'b0100, 1'b1, 4'b1011, 8'h40, 8'h40, 1'b0};
    vec[14] = '{16'h0070, 4'b0100, 1'b1, 4'b1111, 8'hFF, 8'hFF, 1'b0};
    vec[15] = '{16'h00A0, 4'b0000, 1'b0, 4'b1110, 8'hC0, 8'hC0, 1'b1};
    vec[16] = '{16'h00A0, 4'b0000, 1'b0, 4'b1101, 8'hBF, 8'h88, 1'b0};
    vec[17] = '{16'h00A0, 4'b0000, 1'b0, 4'b1011, 8'hC0, 8'hC0, 1'b0};
    vec[18] = '{16'h00A0, 4'b0000, 1'b0, 4'b0111, 8'hC0, 8'hC0, 1'b0};
    vec[19] = '{16'h1234, 4'b0000, 1'b0, 4'b1110, 8'h99, 8'h99, 1'b1};

    rst_n    = 1'b0;
    count    = 16'h1234;
    dp_mask  = 4'b0000;
    blank_lz = 1'b0;
    en       = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("reset an", {4'h0, an}, 8'h0F);
    chk("reset seg", seg, 8'hFF);
    chk("reset frame", {7'h0, frame}, 8'h00);

    startup("start");

    for (int i = 0; i < 20; i++) begin
      count    = vec[i].cnt;
      dp_mask  = vec[i].dp;
      blank_lz = vec[i].blz;
      run_slot($sformatf("vec%0d", i), vec[i].an, vec[i].seg, vec[i].seg_hex, vec[i].frame);
    end

    // Disable during digit 2: dark next edge, index keeps advancing underneath.
    run_slot("en d1", 4'b1101, 8'hB0, 8'hB0, 1'b0);
    run_slot("en d2", 4'b1011, 8'hA4, 8'hA4, 1'b0);
    en = 1'b0;
    step();
    chk("en off an", {4'h0, an}, 8'h0F);
    chk("en off seg", seg, 8'hFF);
    step();
    step();
    chk("en off gap an", {4'h0, an}, 8'h0F);
    step();
    chk("en off drive an", {4'h0, an}, 8'h0F);
    chk("en off drive seg", seg, 8'hFF);
    en = 1'b1;
    step();
    chk("en on an", {4'h0, an}, 8'h07);
    chk("en on seg", seg, 8'hF9);
    step();
    step();
    chk("en on gap frame", {7'h0, frame}, 8'h01);
    step();
    chk("en wrap an", {4'h0, an}, 8'h0E);
    chk("en wrap seg", seg, 8'h99);

    // Reset during digit 2, then a full restart.
    run_slot("rst d1", 4'b1101, 8'hB0, 8'hB0, 1'b0);
    run_slot("rst d2", 4'b1011, 8'hA4, 8'hA4, 1'b0);
    rst_n = 1'b0;
    step();
    chk("mid reset an", {4'h0, an}, 8'h0F);
    chk("mid reset seg", seg, 8'hFF);
    chk("mid reset frame", {7'h0, frame}, 8'h00);
    step();
    startup("restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
